// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM with memory-ready wait counter and sticky timeout.
// Optional feature: define ILLEGAL_TRAP_EN to trap unrecognised opcodes in TRAP (left only by reset).
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] result_src,
    output logic [3:0] state,
    output logic       retired,
    output logic       timeout_err,
    output logic       illegal
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECI    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_TRAP     = 4'd10;

    localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [3:0]    state_q;
    logic [3:0]    next_state;
    logic [CW-1:0] wait_cnt;
    logic          wait_state;
    logic          timeout_hit;
    logic          timeout_q;

    assign state       = state_q;
    assign timeout_err = timeout_q;
    assign wait_state  = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    // A ready in the same cycle the limit is reached completes normally.
    assign timeout_hit = reset && wait_state && !mem_ready && (wait_cnt == LIMIT);

    // Outputs are all held at 0 while reset is low, which also kills any pending write/retire.
    always_comb begin
        next_state = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 4'b0000;
        result_src = 2'b00;
        retired    = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = !timeout_hit;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'b10;
                        result_src = 2'b10;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (opcode)
                        7'b0000011, 7'b0100011: next_state = S_MEMADR;
                        7'b0110011:             next_state = S_EXECR;
                        7'b0010011:             next_state = S_EXECI;
                        7'b1100011:             next_state = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                        default:                next_state = S_TRAP;
`else
                        default:                next_state = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    next_state = (opcode == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    mem_req = !timeout_hit;
                    adr_src = 1'b1;
                    if (mem_ready)        next_state = S_MEMWB;
                    else if (timeout_hit) next_state = S_FETCH;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    retired    = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req = !timeout_hit;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        retired    = 1'b1;
                        next_state = S_FETCH;
                    end else if (timeout_hit) begin
                        next_state = S_FETCH;
                    end
                end
                S_EXECR: begin
                    alu_src_a  = 2'b10;
                    alu_ctrl   = {funct7_5, funct3};
                    next_state = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    // Only shifts (funct3 = 101) use bit 30 to pick SRAI over SRLI.
                    alu_ctrl   = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
                    next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    retired    = 1'b1;
                    next_state = S_FETCH;
                end
                S_BEQ: begin
                    alu_src_a  = 2'b10;
                    alu_ctrl   = 4'b1000;
                    pc_write   = zero;
                    retired    = 1'b1;
                    next_state = S_FETCH;
                end
                S_TRAP:  next_state = S_TRAP;
                default: next_state = S_FETCH;
            endcase
        end
    end

    // The counter restarts on every state entry, including FETCH re-entered after a timeout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (timeout_hit)
                timeout_q <= 1'b1;
            if (timeout_hit || (next_state != state_q))
                wait_cnt <= '0;
            else if (wait_state && !mem_ready)
                wait_cnt <= wait_cnt + CW'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (!reset)
            illegal_q <= 1'b0;
        else if (next_state == S_TRAP)
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors go through a scoreboard queue.
module tb_multicycle_ctrl;
    localparam int W = 21;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, pc_write, ir_write, reg_write, retired;
    logic       timeout_err, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_ctrl, state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .result_src(result_src), .state(state), .retired(retired),
        .timeout_err(timeout_err), .illegal(illegal)
    );

    assign obs = {state, mem_req, mem_we, adr_src, reg_write, retired, pc_write, ir_write,
                  alu_src_a, alu_src_b, result_src, alu_ctrl};

    function automatic logic [W-1:0] mk(input logic [3:0] st, input logic mreq, input logic we,
                                        input logic adr, input logic rw, input logic ret,
                                        input logic pcw, input logic irw, input logic [1:0] sa,
                                        input logic [1:0] sb, input logic [1:0] rs,
                                        input logic [3:0] ac);
        return {st, mreq, we, adr, rw, ret, pcw, irw, sa, sb, rs, ac};
    endfunction

    // Expected vector per state, built from the control table.
    logic [W-1:0] fetch_ok, fetch_wait, fetch_to, decode, memadr, memread, memwb;
    logic [W-1:0] memwrite_ok, aluwb, trap;

    task automatic sample(input string tag);
        logic [W-1:0] e;
        #1;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, e);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic step(input logic [W-1:0] e, input string tag);
        exp_q.push_back(e);
        sample(tag);
        next_cycle();
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] e);
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, e);
        end
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        fetch_ok    = mk(4'd0, 1, 0, 0, 0, 0, 1, 1, 2'b00, 2'b10, 2'b10, 4'h0);
        fetch_wait  = mk(4'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0);
        fetch_to    = mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0);
        decode      = mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 4'h0);
        memadr      = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'h0);
        memread     = mk(4'd3, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0);
        memwb       = mk(4'd4, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b01, 4'h0);
        memwrite_ok = mk(4'd5, 1, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0);
        aluwb       = mk(4'd7, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0);
        trap        = mk(4'd10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0);

        // Reset held for 3 edges with mem_ready high: outputs must stay forced low.
        reset = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", state, 4'd0);
        chk("rst_mem_req", {3'b0, mem_req}, 4'd0);
        chk("rst_ir_write", {3'b0, ir_write}, 4'd0);
        chk("rst_timeout", {3'b0, timeout_err}, 4'd0);
        chk("rst_illegal", {3'b0, illegal}, 4'd0);
        reset = 1'b1;

        // R-type ADD, then SUB.
        step(fetch_ok, "add_fetch");
        step(decode, "add_decode");
        step(mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'h0), "add_execr");
        step(aluwb, "add_aluwb");
        set_instr(7'b0110011, 3'b000, 1'b1);
        step(fetch_ok, "sub_fetch");
        step(decode, "sub_decode");
        step(mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'h8), "sub_execr");
        step(aluwb, "sub_aluwb");

        // I-type: bit 30 ignored for ADDI, honoured for SRAI.
        set_instr(7'b0010011, 3'b000, 1'b1);
        step(fetch_ok, "addi_fetch");
        step(decode, "addi_decode");
        step(mk(4'd8, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'h0), "addi_execi");
        step(aluwb, "addi_aluwb");
        set_instr(7'b0010011, 3'b101, 1'b1);
        step(fetch_ok, "srai_fetch");
        step(decode, "srai_decode");
        step(mk(4'd8, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 4'hD), "srai_execi");
        step(aluwb, "srai_aluwb");

        // Load with three not-ready cycles in MEMREAD.
        set_instr(7'b0000011, 3'b010, 1'b0);
        step(fetch_ok, "lw_fetch");
        step(decode, "lw_decode");
        step(memadr, "lw_memadr");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(memread, "lw_memread_wait");
        mem_ready = 1'b1;
        step(memread, "lw_memread_done");
        step(memwb, "lw_memwb");

        // Store.
        set_instr(7'b0100011, 3'b010, 1'b0);
        step(fetch_ok, "sw_fetch");
        step(decode, "sw_decode");
        step(memadr, "sw_memadr");
        step(memwrite_ok, "sw_memwrite");

        // Branch taken / not taken.
        set_instr(7'b1100011, 3'b000, 1'b0);
        zero = 1'b1;
        step(fetch_ok, "beq1_fetch");
        step(decode, "beq1_decode");
        step(mk(4'd9, 0, 0, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b00, 4'h8), "beq_taken");
        zero = 1'b0;
        step(fetch_ok, "beq0_fetch");
        step(decode, "beq0_decode");
        step(mk(4'd9, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 4'h8), "beq_not_taken");

        // Unrecognised opcode.
        set_instr(7'b1111111, 3'b000, 1'b0);
        step(fetch_ok, "ill_fetch");
        step(decode, "ill_decode");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(trap);
            sample("ill_trap");
            chk("ill_flag", {3'b0, illegal}, 4'd1);
            next_cycle();
        end
        reset = 1'b0;
        next_cycle();
        #1;
        chk("ill_flag_reset", {3'b0, illegal}, 4'd0);
        reset = 1'b1;
`else
        exp_q.push_back(fetch_ok);
        sample("ill_back_to_fetch");
        chk("ill_flag_tied", {3'b0, illegal}, 4'd0);
        next_cycle();
        step(decode, "ill_decode2");
`endif

        // FETCH timeout: 15 wait cycles, then a cycle with mem_req dropped.
        set_instr(7'b0110011, 3'b000, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        step(fetch_ok, "pre_to_fetch");
        step(decode, "pre_to_decode");
        step(mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'h0), "pre_to_execr");
        step(aluwb, "pre_to_aluwb");
`endif
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) step(fetch_wait, "to1_wait");
        exp_q.push_back(fetch_to);
        sample("to1_hit");
        chk("to1_err_before", {3'b0, timeout_err}, 4'd0);
        next_cycle();
        exp_q.push_back(fetch_wait);
        sample("to2_first_wait");
        chk("to_err_set", {3'b0, timeout_err}, 4'd1);
        next_cycle();
        for (int i = 0; i < 14; i++) step(fetch_wait, "to2_wait");
        step(fetch_to, "to2_hit");
        // Ready arriving exactly at the limit beats the timeout.
        for (int i = 0; i < 15; i++) step(fetch_wait, "to3_wait");
        mem_ready = 1'b1;
        step(fetch_ok, "to3_ready_wins");
        step(decode, "to3_decode");
        exp_q.push_back(mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 4'h0));
        sample("to3_execr");
        chk("to_err_sticky", {3'b0, timeout_err}, 4'd1);
        next_cycle();

        // Reset during ALUWB suppresses the write and retire.
        reset = 1'b0;
        #1;
        chk("midrst_state", state, 4'd7);
        chk("midrst_reg_write", {3'b0, reg_write}, 4'd0);
        chk("midrst_retired", {3'b0, retired}, 4'd0);
        next_cycle();
        #1;
        chk("midrst_state_after", state, 4'd0);
        chk("midrst_timeout_clr", {3'b0, timeout_err}, 4'd0);
        reset = 1'b1;
        step(fetch_ok, "post_rst_fetch");
        step(decode, "post_rst_decode");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 15, giving the maximum number of cycles to wait for mem_ready before aborting.
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 reset  in  1  reset; synchronous, active-low.
REQ-004 opcode  in  7  instruction[6:0] taken from the datapath instruction register.
REQ-005 funct3  in  3  instruction[14:12].
REQ-006 funct7_5  in  1  instruction[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  unified memory acknowledge; completes a request in the cycle it is high.
REQ-009 mem_req  out  1  memory request; mem_we  out  1  write enable; adr_src  out  1  address select (0 = PC, 1 = ALU out register).
REQ-010 pc_write  out  1; ir_write  out  1; reg_write  out  1  register-file write enable.
REQ-011 alu_src_a  out  2  (00 = PC, 01 = old PC, 10 = rs1); alu_src_b  out  2  (00 = rs2, 01 = imm, 10 = constant 4).
REQ-012 alu_ctrl  out  4  encoded as {funct7_5, funct3}: ADD = 0000, SUB = 1000.
REQ-013 result_src  out  2  (00 = ALU out register, 01 = memory data, 10 = ALU result).
REQ-014 state  out  4  current FSM state; retired  out  1  one-cycle pulse per completed instruction.
REQ-015 timeout_err  out  1  sticky flag; illegal  out  1  illegal-opcode flag (see Configuration).

Function
REQ-016 State encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, BEQ 9, TRAP 10.
REQ-017 Outputs SHALL be combinational from the state register, mem_ready, zero and the instruction fields; any output not listed for a state SHALL be 0.
REQ-018 FETCH: mem_req = 1 and adr_src = 0; hold the state while mem_ready = 0; when mem_ready = 1, assert ir_write, pc_write, alu_src_a = 00, alu_src_b = 10, ADD and result_src = 10, then go to DECODE.
REQ-019 DECODE: alu_src_a = 01, alu_src_b = 01, ADD (branch target); next state chosen by opcode as follows.
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- any other value -> FETCH, or TRAP per REQ-030
REQ-020 MEMADR: alu_src_a = 10, alu_src_b = 01, ADD; go to MEMREAD if opcode = 0000011, otherwise to MEMWRITE.
REQ-021 MEMREAD: mem_req = 1, adr_src = 1; wait for mem_ready, then go to MEMWB.
MEMWB: result_src = 01, reg_write = 1, retired = 1; then go to FETCH.
REQ-022 MEMWRITE: mem_req = 1, mem_we = 1, adr_src = 1; when mem_ready = 1, assert retired and go to FETCH.
REQ-023 EXECR: alu_src_a = 10, alu_src_b = 00, alu_ctrl = {funct7_5, funct3}; go to ALUWB.
REQ-024 EXECI: alu_src_a = 10, alu_src_b = 01; alu_ctrl = {funct7_5 only when funct3 = 101 (else 0), funct3}; go to ALUWB.
REQ-025 ALUWB: result_src = 00, reg_write = 1, retired = 1; then go to FETCH.
REQ-026 BEQ: alu_src_a = 10, alu_src_b = 00, SUB, result_src = 00, pc_write = zero, retired = 1; then go to FETCH.
REQ-027 Each wait state (FETCH, MEMREAD, MEMWRITE) SHALL use a wait counter with these rules.
- Cleared on state entry.
- Incremented each cycle that mem_ready = 0.
- When it reaches TIMEOUT_CYCLES: set timeout_err, drop mem_req for that cycle, go to FETCH, and do not pulse retired.
- mem_ready = 1 in the same cycle that the count is reached SHALL win; no timeout is taken.

Reset
REQ-028 While reset = 0, at each clk edge: state <= FETCH, wait counter <= 0, timeout_err <= 0, illegal <= 0, and every other output is forced to 0.
REQ-029 After reset deasserts, the first cycle SHALL be FETCH with mem_req = 1. Reset asserted mid-instruction SHALL abort the instruction and suppress any pending reg_write or retired.

Configuration
REQ-030 With ILLEGAL_TRAP_EN defined, an unrecognised opcode in DECODE SHALL go to TRAP. TRAP sets illegal = 1, drives all controls to 0, and is left only by reset.
REQ-031 Without ILLEGAL_TRAP_EN, an unrecognised opcode SHALL go DECODE -> FETCH with no retired pulse, and illegal SHALL be tied to 0.

Verification
REQ-032 reset low 3 cycles, then opcode = 0110011, funct7_5 = 0, mem_ready = 1 -> state sequence 0, 1, 6, 7, 0; reg_write and retired high only in state 7; 4 cycles per instruction.
REQ-033 funct7_5 = 1, funct3 = 000 R-type -> alu_ctrl = 1000 in EXECR. I-type funct3 = 000 with funct7_5 = 1 -> alu_ctrl = 0000.
REQ-034 lw (0000011) with mem_ready low for 3 cycles in MEMREAD -> state 3 held for 4 cycles, then 4 with result_src = 01 and reg_write = 1.
REQ-035 beq with zero = 1 -> pc_write = 1 in state 9; with zero = 0 -> pc_write = 0; retired = 1 in both cases.
REQ-036 mem_ready stuck at 0 with TIMEOUT_CYCLES = 15 -> timeout_err rises after 15 FETCH wait cycles, FETCH is re-entered with the counter restarted, and timeout_err stays 1 until reset.
REQ-037 opcode = 1111111 -> with ILLEGAL_TRAP_EN: state 10 and illegal = 1, held until reset; without it: state returns to 0 and retired never pulses.
